// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps all 2**N_IN input vectors through a FUT and captures its truth table and minterm count.
// Optional TT_MONO_CHECK_EN adds mono_violation, flagging a non-monotone-increasing function.
module tt_sweep_capture #(
  parameter int N_IN = 7,
  parameter int SETTLE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      dut_x,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic [7:0]           ones_count
`ifdef TT_MONO_CHECK_EN
  ,
  output logic                 mono_violation
`endif
);
  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;
  localparam logic [N_IN-1:0] ONE = 1;
  state_t state, state_n;
  logic [3:0] wcnt;
  logic last, sample, accept;
  assign last = &dut_x;
  assign busy = state == SWEEP;
  assign done = state == FINISH;
  assign accept = state == IDLE && start;
  assign sample = busy && !abort && wcnt == 4'd0;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? SWEEP : IDLE) :
              (state == SWEEP) ? (abort ? IDLE : (sample && last) ? FINISH : SWEEP) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      dut_x      <= '0;
      wcnt       <= '0;
      tt         <= '0;
      ones_count <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        dut_x      <= '0;
        wcnt       <= 4'(SETTLE);
        tt         <= '0;
        ones_count <= '0;
      end else if (busy && abort) begin
        dut_x <= '0;
        wcnt  <= '0;
      end else if (busy && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end else if (sample) begin
        tt[dut_x]  <= dut_out;
        ones_count <= ones_count + 8'(dut_out);
        if (!last) begin
          dut_x <= dut_x + ONE;
          wcnt  <= 4'(SETTLE);
        end
      end else if (done) begin
        dut_x <= '0;
      end
    end
`ifdef TT_MONO_CHECK_EN
  // bad[i*N_IN+k]: raising input k from vector i drops the output from 1 to 0
  logic [2**N_IN*N_IN-1:0] bad;
  logic mono_valid;
  for (genvar i = 0; i < 2**N_IN; i++) begin : g_vec
    for (genvar k = 0; k < N_IN; k++) begin : g_bit
      if (((i >> k) & 1) == 0) begin : g_up
        assign bad[i*N_IN+k] = tt[i] & ~tt[i | (1 << k)];
      end else begin : g_na
        assign bad[i*N_IN+k] = 1'b0;
      end
    end
  end
  // tt is final from the FINISH entry edge onward, so the flag gates the live reduction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mono_valid <= 1'b0;
    else if (accept) mono_valid <= 1'b0;
    else if (sample && last) mono_valid <= 1'b1;
  assign mono_violation = mono_valid & (|bad);
`endif
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: table-driven sweeps of known FUTs plus abort, start-collision, reset and SETTLE=3 sequences.
module tb_tt_sweep_capture;
  logic clk = 1'b0;
  logic rst_n, start, start1, abort;
  int mode;
  logic [6:0] dut_x0, dut_x1;
  logic fut0, fut1_q;
  logic busy0, done0, busy1, done1;
  logic [127:0] tt0, tt1;
  logic [7:0] ones0, ones1;
  logic mono0, mono1;
  int tests = 0;
  int fails = 0;
  localparam logic [127:0] MAJ_TT = 128'hfeeaeae8eeaaaaa0faaaaa88e8a8a880;
  always #5 clk = ~clk;
  function automatic logic maj(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
  function automatic logic f(int m, logic [6:0] x);
    logic b;
    b = maj(x[0], x[3], x[4]);
    case (m)
      0: return 1'b0;
      1: return x[0];
      2: return maj(maj(x[0], x[2], x[5]), b, maj(x[0], x[1], maj(x[2], x[6], b)));
      3: return ~x[0];
      4: return x[6] & x[5];
      default: return 1'b1;
    endcase
  endfunction
  assign fut0 = f(mode, dut_x0);
  always @(posedge clk) fut1_q <= f(mode, dut_x1);
  tt_sweep_capture #(.N_IN(7), .SETTLE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_x(dut_x0), .dut_out(fut0),
    .busy(busy0), .done(done0), .tt(tt0), .ones_count(ones0)
`ifdef TT_MONO_CHECK_EN
    , .mono_violation(mono0)
`endif
  );
  tt_sweep_capture #(.N_IN(7), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .dut_x(dut_x1), .dut_out(fut1_q),
    .busy(busy1), .done(done1), .tt(tt1), .ones_count(ones1)
`ifdef TT_MONO_CHECK_EN
    , .mono_violation(mono1)
`endif
  );
`ifndef TT_MONO_CHECK_EN
  assign mono0 = 1'b0;
  assign mono1 = 1'b0;
`endif
  typedef struct {
    int           mode;
    logic [127:0] tt;
    int           ones;
    logic         mono;
  } vec_t;
  vec_t v[6];
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run0(output int lat);
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    chk("busy_after_start", busy0, 1);
    while (!done0 && lat < 300) begin
      step();
      lat++;
    end
  endtask
  initial begin
    int lat, hold_err, ndone;
    v[0] = '{0, 128'h0, 0, 1'b0};
    v[1] = '{1, {32{4'hA}}, 64, 1'b0};
    v[2] = '{2, MAJ_TT, 64, 1'b0};
    v[3] = '{3, {32{4'h5}}, 64, 1'b1};
    v[4] = '{4, {{32{1'b1}}, 96'h0}, 32, 1'b0};
    v[5] = '{5, {128{1'b1}}, 128, 1'b0};
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0; mode = 0;
    step();
    chk("reset_busy_done", {busy0, done0, busy1, done1}, 0);
    chk("reset_dut_x", dut_x0, 0);
    chk("reset_tt_ones", {tt0, ones0}, 0);
    rst_n = 1'b1;
    step();
    for (int t = 0; t < 6; t++) begin
      mode = v[t].mode;
      run0(lat);
      chk("latency", lat, 129);
      chk("tt", tt0, v[t].tt);
      chk("ones_count", ones0, v[t].ones);
`ifdef TT_MONO_CHECK_EN
      chk("mono_violation", mono0, v[t].mono);
`endif
      chk("busy_at_done", busy0, 0);
      step();
      chk("done_one_cycle", done0, 0);
      chk("dut_x_back_to_0", dut_x0, 0);
      chk("tt_persist", tt0, v[t].tt);
    end
    // start while busy is ignored, then abort at vector 40
    mode = 5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored_dut_x", dut_x0, 5);
    chk("start_ignored_busy", busy0, 1);
    for (int i = 0; i < 200 && dut_x0 != 7'd40; i++) step();
    chk("reached_vec40", dut_x0, 40);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_dut_x", dut_x0, 0);
    chk("abort_ones_partial", ones0, 40);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      ndone += int'(done0);
      step();
    end
    chk("abort_no_done", ndone, 0);
    mode = 1;
    run0(lat);
    chk("post_abort_latency", lat, 129);
    chk("post_abort_tt", tt0, {32{4'hA}});
    chk("post_abort_ones", ones0, 64);
    step();
    // start and abort together in IDLE: start wins; then async reset mid-sweep
    mode = 5;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", busy0, 1);
    for (int i = 0; i < 10; i++) step();
    chk("pre_reset_ones", ones0, 10);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {busy0, done0}, 0);
    chk("async_reset_dut_x", dut_x0, 0);
    chk("async_reset_tt_ones", {tt0, ones0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // SETTLE=3 against a registered FUT
    mode = 2;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    lat = 1;
    hold_err = 0;
    while (!done1 && lat < 1000) begin
      if (dut_x1 != 7'((lat - 1) / 4)) hold_err++;
      step();
      lat++;
    end
    chk("settle3_latency", lat, 513);
    chk("settle3_hold", hold_err, 0);
    chk("settle3_tt", tt1, MAJ_TT);
    chk("settle3_ones", ones1, 64);
`ifdef TT_MONO_CHECK_EN
    chk("settle3_mono", mono1, 0);
`endif
    step();
    chk("settle3_done_pulse", done1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential characteriser for 7-input single-output combinational functions, such as majority-gate netlists in the classification set.
- Drives all 128 input vectors into a function-under-test (FUT) and samples its output for each one.
- Assembles the 128-bit truth table, counts minterms, and reports completion.
- Is the reading end of the classification flow: the FUT writes a function, this block reads it back as the hex truth-table word used to name it.

Parameters:
- N_IN, 7, number of FUT inputs; truth-table width is 2**N_IN. Only 7 is supported.
- SETTLE, 0, extra wait cycles per vector before sampling, 0..15; covers a registered or slow FUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  sweep request, sampled only in IDLE
- abort  input  1  cancels the sweep in progress
- dut_x  output  7  vector driven to the FUT; bit k is FUT input xk
- dut_out  input  1  FUT output
- busy  output  1  high from the cycle after start until done or abort
- done  output  1  one-cycle pulse when tt and ones_count are valid
- tt  output  128  truth table; tt[i] = f(x = i), with x0 as the LSB of i
- ones_count  output  8  number of ones in tt, 0..128

Behaviour:
- Reset (async, rst_n=0): state IDLE; dut_x=0, busy=0, done=0, tt=0, ones_count=0, wait counter=0.
- States: IDLE, SWEEP, FINISH.
- IDLE:
  - start=1 moves to SWEEP on the next edge.
  - That same edge sets dut_x=0, busy=1, clears tt and ones_count, and sets the wait counter to SETTLE.
- SWEEP, vector timing:
  - Each vector is held for SETTLE+1 cycles.
  - dut_out is sampled on the clock edge that ends the last cycle of the hold, i.e. when the wait counter is 0.
  - With SETTLE=0 the FUT must be combinational; one vector per cycle.
- SWEEP, sample edge:
  - Write tt[dut_x] = dut_out.
  - ones_count += dut_out, 8-bit, no overflow possible.
  - If dut_x = 127, go to FINISH; otherwise dut_x += 1 and reload the wait counter to SETTLE.
- FINISH:
  - Lasts one cycle with done=1; busy drops at the same edge that raises done.
  - Returns to IDLE next; dut_x returns to 0.
- Results persist: tt and ones_count hold until the next accepted start.
- Sweep latency: first sample edge to done = 128*(SETTLE+1) cycles after the start edge, plus 1.
- start while busy or in FINISH is ignored; it is not queued.
- abort=1 in SWEEP:
  - Next edge goes to IDLE with busy=0 and dut_x=0.
  - done is not asserted; tt and ones_count keep their partial values and are invalid.
  - abort in IDLE or FINISH has no effect; abort has priority over a simultaneous sample.
- start and abort both high in IDLE: start wins.
- dut_x wrap: it never increments past 127; the FINISH transition replaces the increment.
- Reset mid-sweep: immediate return to reset values, no done.

Optional Feature:
- Macro: TT_MONO_CHECK_EN.
- When defined:
  - Adds output mono_violation (1 bit), reset 0 and cleared on an accepted start.
  - In FINISH it is registered as 1 if some i and bit k exist with i[k]=0, tt[i]=1 and tt[i | (1<<k)]=0, i.e. the function is not monotone increasing.
  - It is valid when done=1 and holds until the next start.
  - This check flags netlists that cannot be pure majority/AND/OR without inverters.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- FUT constant 0, SETTLE=0, start pulse -> done exactly 129 cycles after the start edge; tt=0; ones_count=0; mono_violation=0.
- FUT f=x0 -> tt=0xAAAA…AAAA (all 32 hex digits A); ones_count=64; mono_violation=0.
- FUT f=MAJ(MAJ(x0,x2,x5), MAJ(x0,x3,x4), MAJ(x0,x1,MAJ(x2,x6,MAJ(x0,x3,x4)))) -> tt=0xfeeaeae8eeaaaaa0faaaaa88e8a8a880; ones_count=64; mono_violation=0.
- FUT f=~x0 with TT_MONO_CHECK_EN defined -> tt=0x5555…5555; ones_count=64; mono_violation=1.
- SETTLE=3 with a FUT registering its output once -> each dut_x held 4 cycles; tt matches the combinational result; done 513 cycles after the start edge.
- start pulse while busy, then abort at vector 40 -> second start ignored; busy=0 the next cycle; no done pulse; a new start sweeps cleanly; rst_n low mid-sweep -> all outputs return to 0 asynchronously.
